// File: rtl/instr_sequencer.sv
// Hardwired instruction-cycle sequencer for the 16-bit accumulator CPU.
// Optional interrupt cycle is compiled in with `define INTERRUPT_EN.
module instr_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] ir,
  input  logic        dr_zero,
  input  logic        fgi,
  input  logic        fgo,
  input  logic        ien_set,
  input  logic        ien_clr,
  output logic [7:0]  ld,
  output logic [7:0]  inr,
  output logic [7:0]  clr,
  output logic [2:0]  bus_sel,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [1:0]  alu_op,
  output logic        rr_en,
  output logic        io_en,
  output logic [15:0] t,
  output logic        int_cycle,
  output logic        ien,
  output logic        instr_done
);

  logic [3:0]  sc;
  logic        i_q;
  logic [7:0]  d_q;
  logic        r_q;
  logic        ien_q;
  logic [15:0] tdec;
  logic        t0, t1, t2, t3, t4, t5, t6;
  logic        in_int;
  logic        unused_ir;

  assign tdec = 16'h0001 << sc;
  assign {t6, t5, t4, t3, t2, t1, t0} = tdec[6:0];
  // R can only be 1 at T1/T2 if the interrupt cycle was entered at T0
  assign in_int = r_q & ((t0 & run) | t1 | t2);
  assign unused_ir = &{1'b0, ir[11:0]};

  always_comb begin
    ld = '0; inr = '0; clr = '0; bus_sel = '0;
    mem_rd = 1'b0; mem_wr = 1'b0; alu_op = '0;
    rr_en = 1'b0; io_en = 1'b0; instr_done = 1'b0;
    t = '0; int_cycle = 1'b0; ien = 1'b0;
    if (reset) begin
      t = tdec;
      ien = ien_q;
      int_cycle = in_int;
      if (in_int) begin
        if (t0) begin
          clr[0] = 1'b1; bus_sel = 3'd2; ld[5] = 1'b1;
        end else if (t1) begin
          bus_sel = 3'd6; mem_wr = 1'b1; clr[1] = 1'b1;
        end else begin
          inr[1] = 1'b1; instr_done = 1'b1;
        end
      end else if (t0) begin
        if (run) begin
          ld[0] = 1'b1; bus_sel = 3'd2;
        end
      end else if (t1) begin
        mem_rd = 1'b1; bus_sel = 3'd7; ld[4] = 1'b1; inr[1] = 1'b1;
      end else if (t2) begin
        bus_sel = 3'd5; ld[0] = 1'b1;
      end else if (t3) begin
        if (d_q[7]) begin
          rr_en = ~i_q; io_en = i_q; instr_done = 1'b1;
        end else if (i_q) begin
          mem_rd = 1'b1; bus_sel = 3'd7; ld[0] = 1'b1;
        end
      end else if (t4) begin
        if (d_q[0] | d_q[1] | d_q[2] | d_q[6]) begin
          mem_rd = 1'b1; bus_sel = 3'd7; ld[2] = 1'b1;
        end else if (d_q[3]) begin
          bus_sel = 3'd4; mem_wr = 1'b1; instr_done = 1'b1;
        end else if (d_q[4]) begin
          bus_sel = 3'd1; ld[1] = 1'b1; instr_done = 1'b1;
        end else if (d_q[5]) begin
          bus_sel = 3'd2; mem_wr = 1'b1; inr[0] = 1'b1;
        end
      end else if (t5) begin
        if (d_q[0] | d_q[1] | d_q[2]) begin
          ld[3] = 1'b1; instr_done = 1'b1;
          alu_op = d_q[0] ? 2'b01 : (d_q[1] ? 2'b10 : 2'b11);
        end else if (d_q[5]) begin
          bus_sel = 3'd1; ld[1] = 1'b1; instr_done = 1'b1;
        end else if (d_q[6]) begin
          inr[2] = 1'b1;
        end
      end else if (t6) begin
        bus_sel = 3'd3; mem_wr = 1'b1; inr[1] = dr_zero; instr_done = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sc  <= '0;
      i_q <= 1'b0;
      d_q <= '0;
    end else begin
      if (instr_done)
        sc <= '0;
      else if (!(t0 && !run))
        sc <= sc + 4'd1;
      if (t2 && !in_int) begin
        i_q <= ir[15];
        d_q <= 8'h01 << ir[14:12];
      end
    end
  end

`ifdef INTERRUPT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q   <= 1'b0;
      ien_q <= 1'b0;
    end else begin
      if (in_int && t2)
        r_q <= 1'b0;
      else if (ien_q && (fgi || fgo) && (!(t0 || t1 || t2) || (t0 && !run)))
        r_q <= 1'b1;
      if (ien_clr || (in_int && t2))
        ien_q <= 1'b0;
      else if (ien_set)
        ien_q <= 1'b1;
    end
  end
`else
  logic unused_irq;
  assign r_q   = 1'b0;
  assign ien_q = 1'b0;
  assign unused_irq = &{1'b0, fgi, fgo, ien_set, ien_clr};
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Table-driven bench for instr_sequencer: one record per clock cycle with
// hand-computed strobes, plus hand sequences for run hold, mid-instruction reset, interrupts.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, dr_zero, fgi, fgo, ien_set, ien_clr;
  logic [15:0] ir;
  logic [7:0]  ld, inr, clr;
  logic [2:0]  bus_sel;
  logic        mem_rd, mem_wr, rr_en, io_en, int_cycle, ien, instr_done;
  logic [1:0]  alu_op;
  logic [15:0] t;
  logic [51:0] obs;

  int checks = 0;
  int failures = 0;

  instr_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .ir(ir), .dr_zero(dr_zero),
    .fgi(fgi), .fgo(fgo), .ien_set(ien_set), .ien_clr(ien_clr),
    .ld(ld), .inr(inr), .clr(clr), .bus_sel(bus_sel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .alu_op(alu_op),
    .rr_en(rr_en), .io_en(io_en), .t(t), .int_cycle(int_cycle),
    .ien(ien), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  assign obs = {t, ld, inr, clr, bus_sel, mem_rd, mem_wr, alu_op,
                rr_en, io_en, instr_done, int_cycle, ien};

  typedef struct {
    string       nm;
    logic        run;
    logic [15:0] ir;
    logic        dz, fgi, iset, iclr;
    logic [51:0] exp;
  } vec_t;

  vec_t q[$];

  function automatic vec_t mk(string nm, int r, int irv, int dz, int ti,
                              int ld_, int inr_, int clr_, int bus, int rd,
                              int wr, int alu, int rr, int io, int dn);
    vec_t v;
    logic [15:0] one;
    one = 16'h0001;
    v.nm = nm; v.run = 1'(r); v.ir = 16'(irv); v.dz = 1'(dz);
    v.fgi = 1'b0; v.iset = 1'b0; v.iclr = 1'b0;
    v.exp = {one << ti, 8'(ld_), 8'(inr_), 8'(clr_), 3'(bus), 1'(rd),
             1'(wr), 2'(alu), 1'(rr), 1'(io), 1'(dn), 2'b00};
    return v;
  endfunction

  function automatic vec_t irq(vec_t v, int f, int s, int c, int ic, int ie);
    v.fgi = 1'(f); v.iset = 1'(s); v.iclr = 1'(c);
    v.exp[1:0] = {1'(ic), 1'(ie)};
    return v;
  endfunction

  // T0..T2 of any instruction; rmid drives run during T1/T2
  task automatic fetch(string n, int irv, int rmid);
    q.push_back(mk({n, "_t0"}, 1, irv, 0, 0, 'h01, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    q.push_back(mk({n, "_t1"}, rmid, irv, 0, 1, 'h10, 'h02, 0, 7, 1, 0, 0, 0, 0, 0));
    q.push_back(mk({n, "_t2"}, rmid, irv, 0, 2, 'h01, 0, 0, 5, 0, 0, 0, 0, 0, 0));
  endtask

  // caller is positioned at a negedge; returns at the next negedge
  task automatic apply(vec_t v);
    run = v.run; ir = v.ir; dr_zero = v.dz;
    fgi = v.fgi; ien_set = v.iset; ien_clr = v.iclr;
    #1;
    checks++;
    if (obs !== v.exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", v.nm, obs, v.exp);
    end
    @(negedge clk);
  endtask

  task automatic run_q();
    foreach (q[k]) apply(q[k]);
    q.delete();
  endtask

  initial begin
    reset = 1'b0; run = 1'b1; ir = 16'h2005; dr_zero = 1'b0;
    fgi = 1'b0; fgo = 1'b0; ien_set = 1'b0; ien_clr = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_state got=%h exp=0", obs);
    end
    @(negedge clk);
    reset = 1'b1;

    fetch("lda", 'h2005, 1);
    q.push_back(mk("lda_t3", 1, 'h2005, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk("lda_t4", 1, 'h2005, 0, 4, 'h04, 0, 0, 7, 1, 0, 0, 0, 0, 0));
    q.push_back(mk("lda_t5", 1, 'h2005, 0, 5, 'h08, 0, 0, 0, 0, 0, 3, 0, 0, 1));
    fetch("addi", 'h9004, 1);
    q.push_back(mk("addi_t3", 1, 'h9004, 0, 3, 'h01, 0, 0, 7, 1, 0, 0, 0, 0, 0));
    q.push_back(mk("addi_t4", 1, 'h9004, 0, 4, 'h04, 0, 0, 7, 1, 0, 0, 0, 0, 0));
    q.push_back(mk("addi_t5", 1, 'h9004, 0, 5, 'h08, 0, 0, 0, 0, 0, 2, 0, 0, 1));
    fetch("isz1", 'h6010, 1);
    q.push_back(mk("isz1_t3", 1, 'h6010, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk("isz1_t4", 1, 'h6010, 0, 4, 'h04, 0, 0, 7, 1, 0, 0, 0, 0, 0));
    q.push_back(mk("isz1_t5", 1, 'h6010, 0, 5, 0, 'h04, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk("isz1_t6", 1, 'h6010, 1, 6, 0, 'h02, 0, 3, 0, 1, 0, 0, 0, 1));
    fetch("isz0", 'h6010, 1);
    q.push_back(mk("isz0_t3", 1, 'h6010, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk("isz0_t4", 1, 'h6010, 1, 4, 'h04, 0, 0, 7, 1, 0, 0, 0, 0, 0));
    q.push_back(mk("isz0_t5", 1, 'h6010, 1, 5, 0, 'h04, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk("isz0_t6", 1, 'h6010, 0, 6, 0, 0, 0, 3, 0, 1, 0, 0, 0, 1));
    fetch("rr", 'h7800, 1);
    q.push_back(mk("rr_t3", 1, 'h7800, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    fetch("io", 'hF800, 1);
    q.push_back(mk("io_t3", 1, 'hF800, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    fetch("sta", 'h3000, 1);
    q.push_back(mk("sta_t3", 1, 'h3000, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk("sta_t4", 1, 'h3000, 0, 4, 0, 0, 0, 4, 0, 1, 0, 0, 0, 1));
    fetch("buni", 'hC000, 0);
    q.push_back(mk("buni_t3", 0, 'hC000, 0, 3, 'h01, 0, 0, 7, 1, 0, 0, 0, 0, 0));
    q.push_back(mk("buni_t4", 0, 'hC000, 0, 4, 'h02, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    fetch("bsa", 'h5000, 1);
    q.push_back(mk("bsa_t3", 1, 'h5000, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk("bsa_t4", 1, 'h5000, 0, 4, 0, 'h01, 0, 2, 0, 1, 0, 0, 0, 0));
    q.push_back(mk("bsa_t5", 1, 'h5000, 0, 5, 'h02, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    fetch("and", 'h0000, 1);
    q.push_back(mk("and_t3", 1, 'h0000, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk("and_t4", 1, 'h0000, 0, 4, 'h04, 0, 0, 7, 1, 0, 0, 0, 0, 0));
    q.push_back(mk("and_t5", 1, 'h0000, 0, 5, 'h08, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    run_q();

    // run low at T0: no strobes, and the following T0 is still T0
    for (int k = 0; k < 2; k++) begin
      run = 1'b0;
      #1;
      checks++;
      if (obs[35:0] !== '0) begin
        failures++;
        $display("FAIL run_hold%0d got=%h exp=0", k, obs[35:0]);
      end
      @(negedge clk);
    end

    // abandon an ISZ at T5 with reset
    fetch("iszr", 'h6010, 1);
    q.push_back(mk("iszr_t3", 1, 'h6010, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk("iszr_t4", 1, 'h6010, 0, 4, 'h04, 0, 0, 7, 1, 0, 0, 0, 0, 0));
    run_q();
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== '0) begin
      failures++;
      $display("FAIL reset_mid_isz got=%h exp=0", obs);
    end
    @(negedge clk);
    reset = 1'b1;
    fetch("post_rst", 'h7800, 1);
    q.push_back(mk("post_rst_t3", 1, 'h7800, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
    run_q();

`ifdef INTERRUPT_EN
    q.push_back(irq(mk("bun_t0", 1, 'h4000, 0, 0, 'h01, 0, 0, 2, 0, 0, 0, 0, 0, 0), 0, 1, 0, 0, 0));
    q.push_back(irq(mk("bun_t1", 1, 'h4000, 0, 1, 'h10, 'h02, 0, 7, 1, 0, 0, 0, 0, 0), 1, 0, 0, 0, 1));
    q.push_back(irq(mk("bun_t2", 1, 'h4000, 0, 2, 'h01, 0, 0, 5, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 1));
    q.push_back(irq(mk("bun_t3", 1, 'h4000, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 1));
    q.push_back(irq(mk("bun_t4", 1, 'h4000, 0, 4, 'h02, 0, 0, 1, 0, 0, 0, 0, 0, 1), 1, 0, 0, 0, 1));
    q.push_back(irq(mk("rt0", 1, 'h4000, 0, 0, 'h20, 0, 'h01, 2, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 1));
    q.push_back(irq(mk("rt1", 1, 'h4000, 0, 1, 0, 0, 'h02, 6, 0, 1, 0, 0, 0, 0), 0, 0, 0, 1, 1));
    q.push_back(irq(mk("rt2", 1, 'h4000, 0, 2, 0, 'h02, 0, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 1, 1));
    q.push_back(irq(mk("after_t0", 1, 'h7800, 0, 0, 'h01, 0, 0, 2, 0, 0, 0, 0, 0, 0), 0, 1, 1, 0, 0));
    q.push_back(irq(mk("after_t1", 1, 'h7800, 0, 1, 'h10, 'h02, 0, 7, 1, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0));
    run_q();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Hardwired instruction-cycle sequencer for the 16-bit accumulator CPU. It owns the sequence counter and walks each instruction through fetch, decode, optional indirect, and execute. In every timing state it drives the per-register load, increment and clear strobes, the common-bus source select, the memory strobes and the ALU operation. It sits between the instruction register and the register file/bus datapath. Register-reference and I/O instructions are handed off to a separate executor through a one-cycle strobe.

## Interface
- No parameters.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  execution enable; sampled only at T0.
- `ir`  in  16  instruction register contents: [15] = I, [14:12] = opcode, [11:0] = address.
- `dr_zero`  in  1  high when DR == 0.
- `fgi`, `fgo`  in  1 each  input/output device flags.
- `ien_set`, `ien_clr`  in  1 each  interrupt-enable set/clear strobes from the executor.
- `ld`, `inr`, `clr`  out  8 each  register strobes. Bit map: 0 AR, 1 PC, 2 DR, 3 AC, 4 IR, 5 TR, 6 OUTR, 7 reserved (always 0).
- `bus_sel`  out  3  bus source: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 memory.
- `mem_rd`, `mem_wr`  out  1 each  memory read/write strobes.
- `alu_op`  out  2  ALU operation: 00 none, 01 AND, 10 ADD, 11 pass DR.
- `rr_en`, `io_en`  out  1 each  register-reference / I/O execute strobes.
- `t`  out  16  one-hot decode of the 4-bit sequence counter.
- `int_cycle`  out  1  high during the interrupt cycle.
- `ien`  out  1  interrupt-enable flip-flop.
- `instr_done`  out  1  pulse in the last cycle of each instruction or interrupt cycle.

## Operation
- Internal state: 4-bit SC, latched I, latched one-hot D[7:0], R flip-flop, IEN flip-flop.
- Control outputs are a combinational decode of the current state.
- The strobed register updates on the next `clk` edge.
- Every cycle with `instr_done`=1 also clears SC.
- T0, when run=1 and R=0: AR←PC (bus 2, ld[0]).
- T0, when run=0: all outputs 0 and SC holds.
- T1: IR←M[AR] (mem_rd, bus 7, ld[4]), PC←PC+1 (inr[1]).
- T2: AR←IR[11:0] (bus 5, ld[0]); latch I=ir[15] and D=decode(ir[14:12]).
- T3, D7 with I=0: rr_en=1, done.
- T3, D7 with I=1: io_en=1, done.
- T3, not D7 with I=1: AR←M[AR] (mem_rd, bus 7, ld[0]).
- T3, not D7 with I=0: no strobes.
- AND/ADD/LDA (D0/D1/D2):
  - T4: DR←M[AR] (mem_rd, bus 7, ld[2]).
  - T5: ld[3] with alu_op 01/10/11 respectively, done.
- STA (D3), T4: M[AR]←AC (bus 4, mem_wr), done.
- BUN (D4), T4: PC←AR (bus 1, ld[1]), done.
- BSA (D5):
  - T4: M[AR]←PC (bus 2, mem_wr), inr[0].
  - T5: PC←AR (bus 1, ld[1]), done.
- ISZ (D6):
  - T4: DR←M[AR].
  - T5: inr[2].
  - T6: M[AR]←DR (bus 3, mem_wr); inr[1] if dr_zero; done.
- A run fall mid-instruction is ignored; the current instruction completes.
- `ien_clr` has priority over `ien_set`.

## Timing
- Reset asserted: SC=0, I=0, D=0, R=0, IEN=0. All outputs are forced to 0 while reset is low, including t, int_cycle and instr_done.
- Reset release mid-instruction: restart at T0; the partial instruction is abandoned.
- Instruction lengths in cycles, independent of I:
  - Register-reference / I/O: 4.
  - STA, BUN: 5.
  - AND, ADD, LDA, BSA: 6.
  - ISZ: 7.
  - Interrupt cycle: 3.
- SC never exceeds 6 and never wraps.
- `ir` and `dr_zero` are sampled in the cycle that uses them.
- `ir` must be stable from T2 until done.

## Configuration
- `INTERRUPT_EN` defined: interrupt logic is compiled in.
  - R←1 on any edge outside T0–T2, or on a T0 with run=0, when IEN & (fgi|fgo).
  - At T0 with R=1 and run=1, the interrupt cycle runs instead of fetch, with int_cycle=1:
    - RT0: clr[0], TR←PC (bus 2, ld[5]).
    - RT1: M[AR]←TR (bus 6, mem_wr), clr[1].
    - RT2: inr[1], IEN←0, R←0, done.
- `INTERRUPT_EN` undefined: R and IEN are constant 0; `ien` and `int_cycle` tie to 0; fgi, fgo, ien_set and ien_clr are ignored. The ports exist in both builds.

## Test plan
- Reset low during ISZ T5, then release → all outputs 0 while low; next cycle t=0x0001 with ld[0]=1 and bus_sel=2.
- ir=0x2005 (LDA, direct) → 6 cycles; T3 has no strobes; T5 has ld[3]=1, alu_op=11, instr_done=1.
- ir=0x9004 (ADD, indirect) → T3 has mem_rd=1, bus_sel=7, ld[0]=1; T5 has alu_op=10.
- ir=0x6010 (ISZ) with dr_zero=1 at T6 → mem_wr=1, bus_sel=3, inr[1]=1; 7 cycles total.
- ir=0x7800 → T3 has rr_en=1 and instr_done=1; ir=0xF800 → io_en=1. Next cycle is T0.
- INTERRUPT_EN build: ien_set pulse, then fgi=1 during a BUN → next T0 enters RT0–RT2 with clr[0] and ld[5], then mem_wr with bus_sel=6, then inr[1]; afterwards ien=0.
